// File: rtl/axis_detector_arbiter_pkg.sv
`default_nettype none
// ==========================================================================
// axis_detector_arbiter_pkg : shared constants and FSM encoding  (rev 1.0)
// ==========================================================================
package axis_detector_arbiter_pkg;

   localparam int N_REQ      = 4;
   localparam int IDX_WIDTH  = 2;
   localparam int DATA_WIDTH = 128;
   localparam int CNTR_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/axis_detector_arbiter_if.sv
`default_nettype none
// ==========================================================================
// axis_detector_arbiter_if : multi-lane AXIS bundle                (rev 1.0)
// ==========================================================================
interface axis_detector_arbiter_if #(
   parameter int LANES      = 1,
   parameter int DATA_WIDTH = 128,
   parameter int USER_WIDTH = 2
);
   logic [LANES*DATA_WIDTH-1:0] tdata;
   logic [USER_WIDTH-1:0]       tuser;
   logic [LANES-1:0]            tvalid;
   logic [LANES-1:0]            tready;

   modport master (output tdata, output tuser, output tvalid, input  tready);
   modport slave  (input  tdata, input  tuser, input  tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_detector_arbiter_rr_arbiter4.sv
`default_nettype none
// ==========================================================================
// rr_arbiter4 : 4-way round-robin pick starting after last grant   (rev 1.0)
// ==========================================================================
module rr_arbiter4
   import axis_detector_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0]     req,
   input  logic [IDX_WIDTH-1:0] last,
   output logic                 gnt_valid,
   output logic [IDX_WIDTH-1:0] gnt_idx
);
   logic [IDX_WIDTH-1:0] cand;

   // Walk from lowest to highest priority so the nearest requester wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = last;
      cand      = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = last + IDX_WIDTH'(k);
         if (req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/axis_detector_arbiter.sv
`default_nettype none
// ==========================================================================
// axis_detector_arbiter : 4:1 round-robin AXIS event merger with limit
// rev 1.0
// ==========================================================================
module axis_detector_arbiter
   import axis_detector_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = axis_detector_arbiter_pkg::DATA_WIDTH,
   parameter int CNTR_WIDTH = axis_detector_arbiter_pkg::CNTR_WIDTH
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  cfg_run,
   input  logic [CNTR_WIDTH-1:0] cfg_limit,
   axis_detector_arbiter_if.slave  s_axis,
   axis_detector_arbiter_if.master m_axis,
   output logic [CNTR_WIDTH-1:0] sts_count,
   output logic                  sts_done
);
   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
   logic [IDX_WIDTH-1:0]   tuser_q, tuser_d;
   logic [IDX_WIDTH-1:0]   last_q, last_d;
   logic                   tvalid_q, tvalid_d;
   logic [CNTR_WIDTH-1:0]  count_q, count_d;
   logic                   done_q, done_d;
   logic [CNTR_WIDTH-1:0]  count_inc;
   logic [N_REQ-1:0]       tready_c;
   logic                   gnt_valid;
   logic [IDX_WIDTH-1:0]   gnt_idx;

   rr_arbiter4 u_rr (
      .req       (s_axis.tvalid),
      .last      (last_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      state_d   = state_q;
      tdata_d   = tdata_q;
      tuser_d   = tuser_q;
      last_d    = last_q;
      tvalid_d  = tvalid_q;
      count_d   = count_q;
      tready_c  = '0;
      count_inc = (&count_q) ? count_q : count_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (cfg_run) begin
               count_d = '0;
               state_d = ST_ARB;
            end
         end
         ST_ARB: begin
            if (!cfg_run) begin
               state_d = ST_IDLE;
            end else if (gnt_valid) begin
               tready_c[gnt_idx] = 1'b1;
               tdata_d  = s_axis.tdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
               tuser_d  = gnt_idx;
               last_d   = gnt_idx;
               tvalid_d = 1'b1;
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            // A dropped cfg_run only takes effect after the held word leaves.
            if (m_axis.tready) begin
               tvalid_d = 1'b0;
               count_d  = count_inc;
               if ((cfg_limit != '0) && (count_inc == cfg_limit)) state_d = ST_DONE;
               else if (!cfg_run)                                state_d = ST_IDLE;
               else                                              state_d = ST_ARB;
            end
         end
         ST_DONE: begin
            if (!cfg_run) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q  <= ST_IDLE;
         tdata_q  <= '0;
         tuser_q  <= '0;
         last_q   <= IDX_WIDTH'(N_REQ - 1);
         tvalid_q <= 1'b0;
         count_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tdata_q  <= tdata_d;
         tuser_q  <= tuser_d;
         last_q   <= last_d;
         tvalid_q <= tvalid_d;
         count_q  <= count_d;
         done_q   <= done_d;
      end
   end

   assign s_axis.tready = tready_c;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tuser  = tuser_q;
   assign m_axis.tvalid = tvalid_q;
   assign sts_count     = count_q;
   assign sts_done      = done_q;
endmodule
`default_nettype wire
